// File: rtl/four_input_adder_arbiter.sv
// four_input_adder_arbiter
//   Round-robin arbiter that lets four requesters share one external,
//   4-cycle-latency adder. A granted request's four operands and an id tag are
//   registered onto the adder inputs. The tag returns with the result, and the
//   result is steered back to the owning requester as a one-cycle strobe.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en                  1 = grant requests, 0 = stop granting and drain
//   req_valid[3:0]      per-requester request
//   req_data[399:0]     requester i owns [100*i+99:100*i], four 25-bit
//                       sign-magnitude operands (bit 24 = sign)
//   req_ready[3:0]      one-hot grant (combinational)
//   add_data_1..4       registered operands to the shared adder
//   add_ddata_in        registered tag to adder {valid, 0.., id[1:0]}
//   add_ddata_out       tag returned by the adder 4 cycles later
//   add_data_p          adder result, aligned with add_ddata_out
//   res_valid[3:0]      one-hot result strobe to the owning requester
//   res_data[7:0]       result value while res_valid != 0
//   busy                FSM not idle or results still outstanding
module four_input_adder_arbiter #(
  parameter int DELAY_DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [3:0]                  req_valid,
  input  logic [399:0]                req_data,
  output logic [3:0]                  req_ready,
  output logic [24:0]                 add_data_1,
  output logic [24:0]                 add_data_2,
  output logic [24:0]                 add_data_3,
  output logic [24:0]                 add_data_4,
  output logic [DELAY_DATA_WIDTH-1:0] add_ddata_in,
  input  logic [DELAY_DATA_WIDTH-1:0] add_ddata_out,
  input  logic [7:0]                  add_data_p,
  output logic [3:0]                  res_valid,
  output logic [7:0]                  res_data,
  output logic                        busy
);
  localparam int DW = DELAY_DATA_WIDTH;
  // Cycles after reset during which stale tags from the unreset adder
  // pipeline are ignored.
  localparam logic [2:0] DISCARD_CYC = 3'd5;
  localparam logic [2:0] MAX_INFLIGHT = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q;
  logic [1:0]      last_q;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      disc_q;
  logic [24:0]     op1_q, op2_q, op3_q, op4_q;
  logic [DW-1:0]   tag_q, tag_d;
  logic [3:0]      res_valid_q;
  logic [7:0]      res_data_q;

  logic [3:0]      gnt;
  logic [1:0]      gnt_idx;
  logic [1:0]      idx;
  logic            found;
  logic            grant_ok;
  logic            hs;
  logic            ret_vld;
  logic [99:0]     sel_ops;
  logic            unused_tag;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_q;
    idx     = '0;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  // Grants are blocked while reset is held, while en is low (so dropping en
  // stops grants the same cycle), during the post-reset discard window, and
  // if the in-flight count would overflow.
  assign grant_ok  = (state_q == RUN) && en && !rst && (disc_q == 3'd0) &&
                     ((cnt_q != MAX_INFLIGHT) || (res_valid_q != 4'd0));
  assign req_ready = grant_ok ? gnt : 4'd0;
  assign hs        = |(req_valid & req_ready);
  assign sel_ops   = req_data[100*gnt_idx +: 100];

  always_comb begin
    tag_d       = '0;
    tag_d[DW-1] = 1'b1;
    tag_d[1:0]  = gnt_idx;
  end

  assign ret_vld    = add_ddata_out[DW-1] && (disc_q == 3'd0);
  assign cnt_d      = cnt_q + {2'd0, hs} - {2'd0, |res_valid_q};
  // Only the valid bit and the id are meaningful in the returned tag.
  assign unused_tag = ^add_ddata_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 2'd3;
      cnt_q       <= '0;
      disc_q      <= DISCARD_CYC;
      op1_q       <= '0;
      op2_q       <= '0;
      op3_q       <= '0;
      op4_q       <= '0;
      tag_q       <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      if (disc_q != 3'd0) disc_q <= disc_q - 3'd1;
      if (hs) last_q <= gnt_idx;
      cnt_q <= cnt_d;

      // Adder inputs are zero in cycles that carry no request.
      op1_q <= hs ? sel_ops[24:0]  : '0;
      op2_q <= hs ? sel_ops[49:25] : '0;
      op3_q <= hs ? sel_ops[74:50] : '0;
      op4_q <= hs ? sel_ops[99:75] : '0;
      tag_q <= hs ? tag_d : '0;

      res_valid_q <= ret_vld ? (4'd1 << add_ddata_out[1:0]) : 4'd0;
      res_data_q  <= ret_vld ? add_data_p : 8'd0;

      case (state_q)
        IDLE:    if (en) state_q <= RUN;
        RUN:     if (!en) state_q <= DRAIN;
        DRAIN: begin
          if (en)                 state_q <= RUN;
          else if (cnt_q == 3'd0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_data_1   = op1_q;
  assign add_data_2   = op2_q;
  assign add_data_3   = op3_q;
  assign add_data_4   = op4_q;
  assign add_ddata_in = tag_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign busy         = (state_q != IDLE) || (cnt_q != 3'd0);

endmodule

// File: tb/tb_four_input_adder_arbiter.sv
module tb_four_input_adder_arbiter;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [3:0]    req_valid;
  logic [399:0]  req_data;
  logic [3:0]    req_ready;
  logic [24:0]   add_data_1, add_data_2, add_data_3, add_data_4;
  logic [DW-1:0] add_ddata_in, add_ddata_out;
  logic [7:0]    add_data_p;
  logic [3:0]    res_valid;
  logic [7:0]    res_data;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  four_input_adder_arbiter #(.DELAY_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .add_data_1(add_data_1), .add_data_2(add_data_2),
    .add_data_3(add_data_3), .add_data_4(add_data_4),
    .add_ddata_in(add_ddata_in), .add_ddata_out(add_ddata_out),
    .add_data_p(add_data_p), .res_valid(res_valid), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: sum of sign-magnitude operands, clamp below 0 and
  // at 2^20, otherwise the result is sum/4096.
  function automatic int smval(input logic [24:0] v);
    return v[24] ? -int'(v[23:0]) : int'(v[23:0]);
  endfunction

  function automatic logic [7:0] addref(input logic [99:0] ops);
    int s = 0;
    for (int k = 0; k < 4; k++) s += smval(ops[25*k +: 25]);
    if (s < 0) return 8'h00;
    if (s >= (1 << 20)) return 8'hFF;
    return 8'(s >>> 12);
  endfunction

  function automatic logic [99:0] rand_ops();
    logic [99:0] r;
    logic [23:0] m;
    for (int k = 0; k < 4; k++) begin
      m = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom & 32'h7FFFF);
      r[25*k +: 25] = {1'($urandom), m};
    end
    return r;
  endfunction

  // Shared adder: 4-cycle pipeline, not reset.
  logic [DW-1:0] pt [4];
  logic [7:0]    pr [4];
  always @(posedge clk) begin
    pt[0] <= add_ddata_in;
    pr[0] <= addref({add_data_4, add_data_3, add_data_2, add_data_1});
    for (int i = 1; i < 4; i++) begin
      pt[i] <= pt[i-1];
      pr[i] <= pr[i-1];
    end
  end
  assign add_ddata_out = pt[3];
  assign add_data_p    = pr[3];

  // Scoreboard: each accepted request is due back 6 cycles later, in order.
  typedef struct { int due; int id; logic [7:0] val; } exp_t;
  exp_t        q[$];
  exp_t        e;
  int          mlast = 3;
  logic [3:0]  m_ev, m_ew;
  logic [7:0]  m_ed;
  int          m_w;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mlast = 3;
    end else begin
      m_ev = 4'd0;
      m_ed = 8'd0;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_ev = 4'd1 << q[0].id;
        m_ed = q[0].val;
        void'(q.pop_front());
      end
      total++;
      if (res_valid !== m_ev || (m_ev != 4'd0 && res_data !== m_ed)) begin
        bad++;
        $display("FAIL result cyc=%0d got valid=%b data=%h want valid=%b data=%h",
                 cyc, res_valid, res_data, m_ev, m_ed);
      end
      if (req_ready != 4'd0) begin
        m_ew = 4'd0;
        for (int k = 1; k <= 4; k++) begin
          m_w = (mlast + k) % 4;
          if (m_ew == 4'd0 && req_valid[m_w]) m_ew = 4'd1 << m_w;
        end
        total++;
        if (req_ready !== m_ew) begin
          bad++;
          $display("FAIL rr_grant cyc=%0d got=%b want=%b", cyc, req_ready, m_ew);
        end
      end
      if ((req_valid & req_ready) != 4'd0) begin
        for (int k = 0; k < 4; k++) if (req_valid[k] & req_ready[k]) m_w = k;
        e.due = cyc + 6;
        e.id  = m_w;
        e.val = addref(req_data[100*m_w +: 100]);
        q.push_back(e);
        mlast = m_w;
      end
    end
  end

  function automatic int onehot_idx(input logic [3:0] v);
    int r = -1;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Tasks start and end just after a rising edge, where inputs are driven.
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req_valid = 4'd0; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 4'd0) begin bad++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    total++; if ({add_data_1, add_data_2, add_data_3, add_data_4} !== 100'd0) begin
      bad++; $display("FAIL reset_add_data got=%h want=0", {add_data_1, add_data_2, add_data_3, add_data_4}); end
    total++; if (add_ddata_in !== '0) begin bad++; $display("FAIL reset_tag got=%h want=0", add_ddata_in); end
    total++; if (res_valid !== 4'd0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (res_data !== 8'd0) begin bad++; $display("FAIL reset_res_data got=%h want=0", res_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    int t = -1;
    int nrdy = 0;
    logic [DW-1:0] tag0;
    tag0 = '0; tag0[DW-1] = 1'b1;
    req_data = '0;
    req_data[99:0] = {25'h0001000, 25'h1002000, 25'h0003000, 25'h0005000};
    en = 1'b1; req_valid = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != 4'd0) nrdy++;
      if (t < 0 && (req_ready & req_valid) != 4'd0) begin
        t = i;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", req_ready); end
      end
      if (t >= 0 && i == t + 1) begin
        total++; if (add_data_1 !== 25'h0005000 || add_data_3 !== 25'h1002000) begin
          bad++; $display("FAIL single_ops got=%h,%h want=0005000,1002000", add_data_1, add_data_3); end
        total++; if (add_ddata_in !== tag0) begin bad++; $display("FAIL single_tag got=%h want=%h", add_ddata_in, tag0); end
      end
      if (t >= 0 && i == t + 2) begin
        total++; if (add_ddata_in !== '0 || add_data_1 !== 25'd0) begin
          bad++; $display("FAIL idle_adder_in got=%h,%h want=0,0", add_ddata_in, add_data_1); end
      end
      if (t >= 0 && i == t + 6) begin
        total++; if (res_valid !== 4'b0001 || res_data !== 8'h07) begin
          bad++; $display("FAIL single_result got=%b/%h want=0001/07", res_valid, res_data); end
      end
      @(posedge clk); #1;
      if (t >= 0) req_valid = 4'd0;
    end
    total++; if (t < 0) begin bad++; $display("FAIL single_timeout got=no_grant want=grant"); end
    total++; if (nrdy !== 1) begin bad++; $display("FAIL single_ready_cycles got=%0d want=1", nrdy); end
  endtask

  task automatic test_round_robin();
    int prev = -1;
    int ng = 0;
    int w;
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) req_data[100*k +: 100] = rand_ops();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin
        w = onehot_idx(req_ready);
        if (prev >= 0) begin
          total++; if (w != (prev + 1) % 4) begin bad++; $display("FAIL rr_order got=%0d want=%0d", w, (prev + 1) % 4); end
        end
        prev = w;
        ng++;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) req_data[100*k +: 100] = rand_ops();
    end
    total++; if (ng !== 16) begin bad++; $display("FAIL rr_throughput got=%0d want=16", ng); end
    req_valid = 4'd0;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic test_clamp();
    int t2 = -100;
    int t3 = -100;
    req_data[299:200] = {25'h0, 25'h0, 25'h0001000, 25'h1064000};
    req_data[399:300] = {25'h0040000, 25'h0040000, 25'h0040000, 25'h0040000};
    req_valid = 4'b1100;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_valid[2] & req_ready[2]) t2 = i;
      if (req_valid[3] & req_ready[3]) t3 = i;
      if (i == t2 + 6) begin
        total++; if (res_valid !== 4'b0100 || res_data !== 8'h00) begin
          bad++; $display("FAIL clamp_neg got=%b/%h want=0100/00", res_valid, res_data); end
      end
      if (i == t3 + 6) begin
        total++; if (res_valid !== 4'b1000 || res_data !== 8'hFF) begin
          bad++; $display("FAIL clamp_big got=%b/%h want=1000/ff", res_valid, res_data); end
      end
      @(posedge clk); #1;
      if (t2 >= 0) req_valid[2] = 1'b0;
      if (t3 >= 0) req_valid[3] = 1'b0;
    end
    total++; if (t2 < 0 || t3 < 0) begin bad++; $display("FAIL clamp_timeout got=%0d,%0d want=granted", t2, t3); end
  endtask

  task automatic test_drain();
    int nh = 0;
    int np = 0;
    int tdone = -1;
    req_valid = 4'hF;
    en = 1'b1;
    for (int k = 0; k < 4; k++) req_data[100*k +: 100] = rand_ops();
    for (int i = 0; i < 20 && nh < 3; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 4'd0) nh++;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) req_data[100*k +: 100] = rand_ops();
    end
    total++; if (nh !== 3) begin bad++; $display("FAIL drain_issue got=%0d want=3", nh); end
    en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++; if (req_ready !== 4'd0) begin bad++; $display("FAIL drain_ready got=%b want=0", req_ready); end
      end
      if (res_valid != 4'd0) np++;
      if (tdone < 0 && busy === 1'b0) begin
        tdone = i;
        total++; if (np !== 3) begin bad++; $display("FAIL drain_pulses got=%0d want=3", np); end
      end
      if (tdone < 0 && np < 3) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b want=1", busy); end
      end
      @(posedge clk); #1;
    end
    total++; if (tdone < 0) begin bad++; $display("FAIL drain_timeout got=busy want=idle"); end
    req_valid = 4'd0;
  endtask

  task automatic test_random();
    int wt [4] = '{0, 0, 0, 0};
    logic [3:0] v = 4'd0;
    int w;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (!v[k] && $urandom_range(0, 2) == 0) begin
          v[k] = 1'b1;
          req_data[100*k +: 100] = rand_ops();
        end
      end
      req_valid = v;
      en = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      if ((req_valid & req_ready) != 4'd0) begin
        w = onehot_idx(req_valid & req_ready);
        total++; if (wt[w] > 3) begin bad++; $display("FAIL fairness req=%0d waited=%0d want<=3", w, wt[w]); end
        wt[w] = 0;
        for (int k = 0; k < 4; k++) if (k != w && v[k]) wt[k]++;
        v[w] = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 4'd0;
    en = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid();
    int nh = 0;
    int t = -1;
    logic [7:0] ex;
    en = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) req_data[100*k +: 100] = rand_ops();
    for (int i = 0; i < 20 && nh < 4; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 4'd0) nh++;
      @(posedge clk); #1;
    end
    total++; if (nh !== 4) begin bad++; $display("FAIL rstmid_issue got=%0d want=4", nh); end
    req_valid = 4'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (res_valid !== 4'd0) begin bad++; $display("FAIL rstmid_stale got=%b want=0", res_valid); end
      @(posedge clk); #1;
    end
    req_data[199:100] = rand_ops();
    ex = addref(req_data[199:100]);
    req_valid = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (t < 0 && (req_valid & req_ready) != 4'd0) t = i;
      if (t >= 0 && i == t + 6) begin
        total++; if (res_valid !== 4'b0010 || res_data !== ex) begin
          bad++; $display("FAIL rstmid_result got=%b/%h want=0010/%h", res_valid, res_data, ex); end
      end
      @(posedge clk); #1;
      if (t >= 0) req_valid = 4'd0;
    end
    total++; if (t < 0) begin bad++; $display("FAIL rstmid_timeout got=no_grant want=grant"); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = 4'd0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_clamp();
    test_drain();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
